// File: rtl/mold_ab_arb.sv
// Packet-level A/B arbiter that shares one MoldUDP64 parser between two redundant UDP AXI-stream feeds.
// Optional stall timeout with synthetic packet termination: define MOLD_AB_TIMEOUT_EN.
module mold_ab_arb #(
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_KEEP_W  = AXI_DATA_W / 8,
  parameter int PKT_CNT_W   = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  udp_a_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] udp_a_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] udp_a_axis_tdata_i,
  input  logic                  udp_a_axis_tlast_i,
  input  logic                  udp_a_axis_tuser_i,
  output logic                  udp_a_axis_tready_o,
  input  logic                  udp_b_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] udp_b_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] udp_b_axis_tdata_i,
  input  logic                  udp_b_axis_tlast_i,
  input  logic                  udp_b_axis_tuser_i,
  output logic                  udp_b_axis_tready_o,
  output logic                  udp_axis_tvalid_o,
  output logic [AXI_KEEP_W-1:0] udp_axis_tkeep_o,
  output logic [AXI_DATA_W-1:0] udp_axis_tdata_o,
  output logic                  udp_axis_tlast_o,
  output logic                  udp_axis_tuser_o,
  input  logic                  udp_axis_tready_i,
  output logic [1:0]            gnt_o,
  output logic [PKT_CNT_W-1:0]  pkt_cnt_a_o,
  output logic [PKT_CNT_W-1:0]  pkt_cnt_b_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GNT_A   = 3'd1;
  localparam logic [2:0] ST_GNT_B   = 3'd2;
  localparam logic [2:0] ST_DRAIN_A = 3'd3;
  localparam logic [2:0] ST_DRAIN_B = 3'd4;

  logic [2:0]           state_r, state_s;
  logic                 last_r, last_s;   // 1'b1 = feed B was served last
  logic [1:0]           gnt_r, gnt_s;
  logic [PKT_CNT_W-1:0] cnt_a_r, cnt_b_r;
  logic                 inc_a_s, inc_b_s;
  logic                 acc_s;

`ifdef MOLD_AB_TIMEOUT_EN
  localparam int STALL_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYC - 1);

  logic [STALL_W-1:0] stall_r, stall_s;
  logic               syn_r, syn_s;      // synthetic terminator offered but not yet taken
  logic               syn_drv_s;

  // Decide whether the synthetic terminating beat owns the output this cycle.
  always_comb begin
    syn_drv_s = 1'b0;
    case (state_r)
      ST_GNT_A: syn_drv_s = syn_r | ((stall_r == STALL_MAX) & ~udp_a_axis_tvalid_i);
      ST_GNT_B: syn_drv_s = syn_r | ((stall_r == STALL_MAX) & ~udp_b_axis_tvalid_i);
      default:  syn_drv_s = 1'b0;
    endcase
  end
`endif

  // Output mux and ready steering; the granted feed passes through with zero latency.
  always_comb begin
    udp_axis_tvalid_o   = 1'b0;
    udp_axis_tkeep_o    = '0;
    udp_axis_tdata_o    = '0;
    udp_axis_tlast_o    = 1'b0;
    udp_axis_tuser_o    = 1'b0;
    udp_a_axis_tready_o = 1'b0;
    udp_b_axis_tready_o = 1'b0;
    case (state_r)
      ST_GNT_A: begin
`ifdef MOLD_AB_TIMEOUT_EN
        if (syn_drv_s) begin
          udp_axis_tvalid_o = 1'b1;
          udp_axis_tlast_o  = 1'b1;
          udp_axis_tuser_o  = 1'b1;
        end else begin
          udp_axis_tvalid_o   = udp_a_axis_tvalid_i;
          udp_axis_tkeep_o    = udp_a_axis_tkeep_i;
          udp_axis_tdata_o    = udp_a_axis_tdata_i;
          udp_axis_tlast_o    = udp_a_axis_tlast_i;
          udp_axis_tuser_o    = udp_a_axis_tuser_i;
          udp_a_axis_tready_o = udp_axis_tready_i;
        end
`else
        udp_axis_tvalid_o   = udp_a_axis_tvalid_i;
        udp_axis_tkeep_o    = udp_a_axis_tkeep_i;
        udp_axis_tdata_o    = udp_a_axis_tdata_i;
        udp_axis_tlast_o    = udp_a_axis_tlast_i;
        udp_axis_tuser_o    = udp_a_axis_tuser_i;
        udp_a_axis_tready_o = udp_axis_tready_i;
`endif
      end
      ST_GNT_B: begin
`ifdef MOLD_AB_TIMEOUT_EN
        if (syn_drv_s) begin
          udp_axis_tvalid_o = 1'b1;
          udp_axis_tlast_o  = 1'b1;
          udp_axis_tuser_o  = 1'b1;
        end else begin
          udp_axis_tvalid_o   = udp_b_axis_tvalid_i;
          udp_axis_tkeep_o    = udp_b_axis_tkeep_i;
          udp_axis_tdata_o    = udp_b_axis_tdata_i;
          udp_axis_tlast_o    = udp_b_axis_tlast_i;
          udp_axis_tuser_o    = udp_b_axis_tuser_i;
          udp_b_axis_tready_o = udp_axis_tready_i;
        end
`else
        udp_axis_tvalid_o   = udp_b_axis_tvalid_i;
        udp_axis_tkeep_o    = udp_b_axis_tkeep_i;
        udp_axis_tdata_o    = udp_b_axis_tdata_i;
        udp_axis_tlast_o    = udp_b_axis_tlast_i;
        udp_axis_tuser_o    = udp_b_axis_tuser_i;
        udp_b_axis_tready_o = udp_axis_tready_i;
`endif
      end
`ifdef MOLD_AB_TIMEOUT_EN
      ST_DRAIN_A: udp_a_axis_tready_o = 1'b1;
      ST_DRAIN_B: udp_b_axis_tready_o = 1'b1;
`endif
      default: begin
        udp_axis_tvalid_o = 1'b0;
      end
    endcase
  end

  assign acc_s = udp_axis_tvalid_o & udp_axis_tready_i;

  // Next-state, round-robin pointer, packet-count strobes and stall tracking.
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    inc_a_s = 1'b0;
    inc_b_s = 1'b0;
`ifdef MOLD_AB_TIMEOUT_EN
    stall_s = '0;
    syn_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (udp_a_axis_tvalid_i && udp_b_axis_tvalid_i) begin
          state_s = last_r ? ST_GNT_A : ST_GNT_B;
        end else if (udp_a_axis_tvalid_i) begin
          state_s = ST_GNT_A;
        end else if (udp_b_axis_tvalid_i) begin
          state_s = ST_GNT_B;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GNT_A: begin
`ifdef MOLD_AB_TIMEOUT_EN
        if (syn_drv_s) begin
          if (udp_axis_tready_i) begin
            state_s = ST_DRAIN_A;
          end else begin
            syn_s   = 1'b1;
            stall_s = stall_r;
          end
        end else if (acc_s) begin
          stall_s = '0;
        end else if (!udp_a_axis_tvalid_i && (stall_r != STALL_MAX)) begin
          stall_s = stall_r + STALL_W'(1);
        end else begin
          stall_s = stall_r;
        end
`endif
        if (acc_s && udp_axis_tlast_o && !udp_axis_tuser_o) begin
          inc_a_s = 1'b1;
        end else if (acc_s && udp_axis_tlast_o && udp_a_axis_tready_o) begin
          inc_a_s = 1'b1;
        end else begin
          inc_a_s = 1'b0;
        end
        if (acc_s && udp_axis_tlast_o && udp_a_axis_tready_o) begin
          last_s = 1'b0;
          if (udp_b_axis_tvalid_i) begin
            state_s = ST_GNT_B;
          end else if (udp_a_axis_tvalid_i) begin
            state_s = ST_GNT_A;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          last_s = last_r;
        end
      end
      ST_GNT_B: begin
`ifdef MOLD_AB_TIMEOUT_EN
        if (syn_drv_s) begin
          if (udp_axis_tready_i) begin
            state_s = ST_DRAIN_B;
          end else begin
            syn_s   = 1'b1;
            stall_s = stall_r;
          end
        end else if (acc_s) begin
          stall_s = '0;
        end else if (!udp_b_axis_tvalid_i && (stall_r != STALL_MAX)) begin
          stall_s = stall_r + STALL_W'(1);
        end else begin
          stall_s = stall_r;
        end
`endif
        if (acc_s && udp_axis_tlast_o && udp_b_axis_tready_o) begin
          inc_b_s = 1'b1;
          last_s  = 1'b1;
          if (udp_a_axis_tvalid_i) begin
            state_s = ST_GNT_A;
          end else if (udp_b_axis_tvalid_i) begin
            state_s = ST_GNT_B;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          inc_b_s = 1'b0;
        end
      end
`ifdef MOLD_AB_TIMEOUT_EN
      ST_DRAIN_A: begin
        if (udp_a_axis_tvalid_i && udp_a_axis_tlast_i) begin
          state_s = ST_IDLE;
          last_s  = 1'b0;
        end else begin
          state_s = ST_DRAIN_A;
        end
      end
      ST_DRAIN_B: begin
        if (udp_b_axis_tvalid_i && udp_b_axis_tlast_i) begin
          state_s = ST_IDLE;
          last_s  = 1'b1;
        end else begin
          state_s = ST_DRAIN_B;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Grant vector follows the next state so gnt_o is a register aligned with state_r.
  always_comb begin
    case (state_s)
      ST_GNT_A, ST_DRAIN_A: gnt_s = 2'b01;
      ST_GNT_B, ST_DRAIN_B: gnt_s = 2'b10;
      default:              gnt_s = 2'b00;
    endcase
  end

  // State, pointer, grant and packet counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      last_r  <= 1'b1;
      gnt_r   <= 2'b00;
      cnt_a_r <= '0;
      cnt_b_r <= '0;
`ifdef MOLD_AB_TIMEOUT_EN
      stall_r <= '0;
      syn_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
      gnt_r   <= gnt_s;
      if (inc_a_s) begin
        cnt_a_r <= cnt_a_r + PKT_CNT_W'(1);
      end
      if (inc_b_s) begin
        cnt_b_r <= cnt_b_r + PKT_CNT_W'(1);
      end
`ifdef MOLD_AB_TIMEOUT_EN
      stall_r <= stall_s;
      syn_r   <= syn_s;
`endif
    end
  end

  assign gnt_o       = gnt_r;
  assign pkt_cnt_a_o = cnt_a_r;
  assign pkt_cnt_b_o = cnt_b_r;

endmodule

// File: doc/mold_ab_arb.md
Name: mold_ab_arb

Overview:
- Packet-level arbiter sharing one MoldUDP64 parser datapath between two redundant UDP AXI-stream feeds (line A and line B).
- Grants one feed at a time and holds the grant for a whole packet, up to tlast.
- Forwards the granted beats unmodified to the parser's udp_axis input.
- Sits between the two UDP receive stacks and the MoldUDP64 top.

Parameters:
- AXI_DATA_W, 64, stream data width.
- AXI_KEEP_W, AXI_DATA_W/8, tkeep width.
- PKT_CNT_W, 32, width of per-feed forwarded-packet counters.
- TIMEOUT_CYC, 256, mid-packet stall limit in cycles (used only with MOLD_AB_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- udp_a_axis_tvalid_i / _tkeep_i / _tdata_i / _tlast_i / _tuser_i  in  1/AXI_KEEP_W/AXI_DATA_W/1/1  feed A stream.
- udp_a_axis_tready_o  out  1  feed A ready.
- udp_b_axis_tvalid_i / _tkeep_i / _tdata_i / _tlast_i / _tuser_i  in  1/AXI_KEEP_W/AXI_DATA_W/1/1  feed B stream.
- udp_b_axis_tready_o  out  1  feed B ready.
- udp_axis_tvalid_o / _tkeep_o / _tdata_o / _tlast_o / _tuser_o  out  1/AXI_KEEP_W/AXI_DATA_W/1/1  stream to parser.
- udp_axis_tready_i  in  1  parser ready.
- gnt_o  out  2  one-hot current grant, {B,A}; 00 when idle.
- pkt_cnt_a_o, pkt_cnt_b_o  out  PKT_CNT_W  packets forwarded per feed.

Behaviour:
- States: IDLE, GNT_A, GNT_B, DRAIN_A, DRAIN_B. The DRAIN states exist only with the feature enabled.
- Reset values:
  - state = IDLE, gnt_o = 00, both counters = 0.
  - Round-robin pointer last = B, so A wins the first tie.
  - All tready_o = 0, udp_axis_tvalid_o = 0.
- IDLE:
  - No tready asserted, output tvalid = 0.
  - Only A valid -> GNT_A next cycle; only B valid -> GNT_B.
  - Both valid -> the feed other than last.
  - Arbitration costs exactly one bubble cycle from IDLE.
- GNT_x datapath:
  - Output tvalid/tkeep/tdata/tlast/tuser are a combinational mux of feed x. Zero latency, no registering.
  - udp_x_axis_tready_o = udp_axis_tready_i; the other feed's tready = 0.
  - A beat is accepted when tvalid & tready on the output.
- End of packet (accepted beat with tlast = 1):
  - pkt_cnt_x increments (wraps modulo 2^PKT_CNT_W), last <= x.
  - If the other feed is valid that same cycle -> go directly to its GNT state (no bubble).
  - Else if feed x is valid and the other is not -> stay GNT_x.
  - Else -> IDLE.
- Mid-packet: grant never changes; the other feed is back-pressured indefinitely.
- tuser is forwarded transparently; a tuser = 1 packet still counts as forwarded.
- tkeep is forwarded unmodified; no compaction.
- Reset asserted mid-packet:
  - Immediate return to IDLE, all tready = 0.
  - Partial packet abandoned; the parser is reset with the same reset.
- gnt_o mirrors state: 01 in GNT_A/DRAIN_A, 10 in GNT_B/DRAIN_B.

Optional Feature:
- Macro: MOLD_AB_TIMEOUT_EN.
- With it:
  - A stall counter clears on every accepted beat and on entry to GNT_x.
  - It increments each cycle in GNT_x while feed x tvalid = 0.
  - At count == TIMEOUT_CYC-1 the block drives one synthetic terminating beat to the parser: tvalid = 1, tlast = 1, tuser = 1, tkeep = 0, tdata = 0.
    - The synthetic beat is held until udp_axis_tready_i.
    - It is not counted in pkt_cnt.
  - Then state -> DRAIN_x:
    - udp_x_axis_tready_o = 1 unconditionally; output tvalid = 0.
    - Feed x beats are discarded until an accepted tlast, then -> IDLE with last <= x.
  - If feed x delivers a beat in the same cycle the count expires, the beat wins and the counter clears.
- Without it: no counter, no DRAIN states; a stalled feed holds the grant forever.

Test Plan:
- A sends one 8-beat packet (tkeep last beat 0x0F), B idle:
  - gnt_o = 01 one cycle after A tvalid.
  - Output matches A bit-exact, pkt_cnt_a_o = 1, B tready stays 0.
- A and B both valid from reset with 3-beat packets:
  - A forwarded first, then B with no idle cycle between A's tlast and B's first beat.
  - Counters end at 1 and 1.
- B mid-packet, A raises tvalid:
  - A tready = 0 until B's tlast is accepted; B packet is not interleaved.
- Parser deasserts udp_axis_tready_i for 5 cycles mid-packet:
  - Granted feed's tready follows it; no beat lost or duplicated.
  - Output tdata is stable while stalled.
- Reset pulsed during beat 2 of an A packet:
  - All outputs return to reset values asynchronously; counters = 0.
  - Next packet from B is granted normally.
- MOLD_AB_TIMEOUT_EN, TIMEOUT_CYC = 16, A stops after 2 beats:
  - Exactly 16 cycles later a tlast/tuser = 1/tkeep = 0 beat appears on the output.
  - A's remaining 3 beats are sunk with tready = 1; pkt_cnt_a_o stays 0.
  - B is granted afterwards.
